// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths
// and the wait-counter width helper used by masters and slaves.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Never returns 0 so a disabled timer still has a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter with an expiry flag.
// Ports: clk, rst_n, clear, enable (count this cycle), expired.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W:0] LIM_V = (W + 1)'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Flags the stall cycle that would make the count reach LIMIT,
    // so the abort lands exactly LIMIT access cycles in.
    assign expired = (LIMIT != 0) && enable
                     && (({1'b0, count} + 1'b1) == LIM_V);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 initiator: one valid/ready command -> one APB transfer -> one response.
// Ports: PCLK/PRESERN, cmd_* stream, rsp_* pulse, APB P* bus signals.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e state, state_nxt;

    logic accept;
    logic done;
    logic abort;
    logic stall;
    logic expired;

    assign accept = (state == IDLE) && cmd_valid;
    assign stall  = (state == ACCESS) && !PREADY;
    assign done   = (state == ACCESS) && PREADY;
    assign abort  = stall && expired;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (PCLK),
        .rst_n   (PRESERN),
        .clear   (accept),
        .enable  (stall),
        .expired (expired)
    );

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus strobes decode the state register only, so nothing on the
    // APB input side reaches an output combinationally.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = SETUP;
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || expired) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomized bench for apb_master_ctrl with a behavioural APB slave
// and a transaction-level reference of latency and response.
module tb_apb_master_ctrl;

    localparam int T = 16;

    logic       PCLK = 1'b0;
    logic       PRESERN;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    apb_master_ctrl #(
        .ADDR_W         (8),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .PCLK        (PCLK),
        .PRESERN     (PRESERN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int tests = 0;
    int fails = 0;

    logic [7:0] smem [256];
    logic [7:0] mmem [256];
    int         plan_wait = 0;
    logic       plan_err = 1'b0;
    int         acc_n = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Slave: PREADY low for plan_wait access cycles; outside a
    // completing access the status lines carry noise.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY  = (acc_n >= plan_wait);
            PSLVERR = PREADY ? plan_err : 1'($urandom);
            PRDATA  = PWRITE ? 8'($urandom) : smem[PADDR];
            acc_n++;
        end else begin
            acc_n   = 0;
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = 8'($urandom);
        end
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
            smem[PADDR] <= PWDATA;
    end

    // Called at a falling edge; returns at the falling edge of the
    // response cycle with cmd_valid still high.
    task automatic do_cmd(input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input int w,
                          input logic e);
        logic       to;
        logic [7:0] xr;
        int         lat;
        int         n_sel;
        int         n_en;
        logic       seen;
        plan_wait = w;
        plan_err  = e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        chk("accept_ready", cmd_ready, 1);
        @(posedge PCLK);
        to    = (w >= T);
        lat   = to ? T + 2 : w + 3;
        xr    = (wr || to) ? 8'h00 : mmem[a];
        seen  = 1'b0;
        n_sel = 0;
        n_en  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                seen = 1'b1;
                chk("latency", i, lat);
                chk("rdata", rsp_rdata, xr);
                chk("err", rsp_err, to ? 1'b1 : e);
                chk("timeout", rsp_timeout, to);
                chk("sel_cycles", n_sel, to ? T + 1 : w + 2);
                chk("en_cycles", n_en, to ? T : w + 1);
                chk("rsp_psel", PSEL, 0);
                chk("rsp_ready", cmd_ready, 1);
            end else begin
                n_sel += int'(PSEL);
                n_en  += int'(PENABLE);
                chk("busy_ready", cmd_ready, 0);
                chk("paddr", PADDR, a);
                chk("pwrite", PWRITE, wr);
                if (wr) chk("pwdata", PWDATA, d);
                cmd_write = 1'($urandom);
                cmd_addr  = 8'($urandom);
                cmd_wdata = 8'($urandom);
            end
        end
        chk("rsp_seen", seen, 1);
        if (wr && !e && !to) mmem[a] = d;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(negedge PCLK);
            chk("idle_rsp", rsp_valid, 0);
            chk("idle_ready", cmd_ready, 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        logic       wr;
        logic       e;
        int         w;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) begin
            mmem[i] = 8'($urandom);
            smem[i] = mmem[i];
        end
        mmem[8'h3C] = 8'h5A;
        smem[8'h3C] = 8'h5A;

        PRESERN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        #1;
        chk("reset_outs",
            {PSEL, PENABLE, PWRITE, PADDR, PWDATA,
             rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESERN = 1'b1;
        idle(2);

        do_cmd(1'b1, 8'h08, 8'hA5, 0, 1'b0);
        idle(1);
        do_cmd(1'b0, 8'h08, 8'h00, 0, 1'b0);
        idle(1);
        do_cmd(1'b0, 8'h3C, 8'h00, 3, 1'b0);
        idle(1);
        do_cmd(1'b1, 8'hFC, 8'h77, 0, 1'b1);
        idle(1);
        do_cmd(1'b0, 8'hFC, 8'h00, 1, 1'b0);
        idle(1);

        do_cmd(1'b0, 8'h10, 8'h00, 100, 1'b0);
        do_cmd(1'b1, 8'h10, 8'hC3, 0, 1'b0);
        do_cmd(1'b0, 8'h10, 8'h00, T - 1, 1'b0);
        do_cmd(1'b1, 8'h11, 8'h3E, T, 1'b0);
        do_cmd(1'b0, 8'h11, 8'h00, 0, 1'b0);
        idle(2);

        for (int k = 0; k < 4; k++)
            do_cmd(1'b1, 8'(8'h20 + k), 8'($urandom), 0, 1'b0);
        for (int k = 0; k < 4; k++)
            do_cmd(1'b0, 8'(8'h20 + k), 8'h00, 0, 1'b0);
        idle(2);

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            a  = 8'($urandom_range(0, 31));
            e  = ($urandom_range(0, 3) == 0);
            w  = ($urandom_range(0, 5) == 0) ? $urandom_range(12, 20)
                                              : $urandom_range(0, 3);
            do_cmd(wr, a, 8'($urandom), w, e);
            if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 3));
        end
        idle(1);

        plan_wait = 10;
        plan_err  = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h77;
        cmd_wdata = 8'h9D;
        @(posedge PCLK);
        cmd_valid = 1'b0;
        repeat (3) @(posedge PCLK);
        #2;
        PRESERN = 1'b0;
        #1;
        chk("midrst_outs",
            {PSEL, PENABLE, PWRITE, PADDR, PWDATA,
             rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
        @(negedge PCLK);
        PRESERN = 1'b1;
        idle(5);
        do_cmd(1'b0, 8'h77, 8'h00, 0, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
